// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
package mult_arb_pkg;

  localparam int DEF_W = 12;
  localparam int DEF_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Requester ID reached by stepping 'offset' places past 'base', wrapping at n.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Request/result bundle between the requesters and the shared multiplier arbiter.
import mult_arb_pkg::*;

interface mult_arbiter_if #(
  parameter int W = DEF_W,
  parameter int N = DEF_N
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]     req_i;
  logic [N*W-1:0]   a_i;
  logic [N*W-1:0]   b_i;
  logic [N-1:0]     ack_o;
  logic             busy_o;
  logic [2*W-1:0]   res_o;
  logic             res_valid_o;
  logic [IDW-1:0]   res_id_o;

  modport master (
    output req_i, a_i, b_i,
    input  ack_o, busy_o, res_o, res_valid_o, res_id_o
  );

  modport slave (
    input  req_i, a_i, b_i,
    output ack_o, busy_o, res_o, res_valid_o, res_id_o
  );
endinterface

// File: rtl/shift_add_core.sv
// Unsigned W-cycle LSB-first shift-add multiplier. The multiplier register
// doubles as the low half of the product: each step shifts the accumulator's
// LSB into its top while consuming its own LSB as the add-enable.
module shift_add_core
  import mult_arb_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           done
);
  localparam int CW = $clog2(W + 1);

  logic          running;
  logic [CW-1:0] step;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic [W:0]    acc;
  logic [W:0]    sum;

  // Partial sum keeps the carry so the largest operands stay exact.
  always_comb begin
    sum = acc + {1'b0, (mplier[0] ? mcand : {W{1'b0}})};
  end

  // Load on start when idle, then one shift-add step per cycle for W cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running <= 1'b0;
      step    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
    end else if (!running) begin
      if (start) begin
        mcand   <= a;
        mplier  <= b;
        acc     <= '0;
        step    <= '0;
        running <= 1'b1;
      end
    end else begin
      acc    <= {1'b0, sum[W:1]};
      mplier <= {sum[0], mplier[W-1:1]};
      step   <= step + 1'b1;
      if (step == CW'(W - 1)) begin
        running <= 1'b0;
      end
    end
  end

  // High during the final step: product is complete from the next cycle on.
  assign done    = running && (step == CW'(W - 1));
  assign product = {acc[W-1:0], mplier};

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one shift-add multiplier among N requesters.
// The pointer holds the last served ID; the search starts one past it.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input logic           clk,
  input logic           rst_n,
  mult_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N);

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id;
  logic [IDW-1:0]   winner;
  logic             found;

  logic [N-1:0]     ack;
  logic             busy;
  logic [2*W-1:0]   res;
  logic             res_valid;
  logic [IDW-1:0]   res_id;

  logic [W-1:0]     core_a;
  logic [W-1:0]     core_b;
  logic             core_start;
  logic             core_done;
  logic [2*W-1:0]   core_product;

  // Pick the first active request after the pointer, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 1; i <= N; i++) begin
      if (!found && bus.req_i[rr_index(int'(ptr), i, N)]) begin
        found  = 1'b1;
        winner = IDW'(rr_index(int'(ptr), i, N));
      end
    end
  end

  assign core_a     = bus.a_i[winner*W +: W];
  assign core_b     = bus.b_i[winner*W +: W];
  assign core_start = (state == ST_IDLE) && found;

  shift_add_core #(.W(W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (core_start),
    .a       (core_a),
    .b       (core_b),
    .product (core_product),
    .done    (core_done)
  );

  // Sequence grant, multiply and result publication; pulses default low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= IDW'(N - 1);
      id        <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      res       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
    end else begin
      ack       <= '0;
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            ack   <= {{(N-1){1'b0}}, 1'b1} << winner;
            id    <= winner;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (core_done) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          res       <= core_product;
          res_id    <= id;
          res_valid <= 1'b1;
          ptr       <= id;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_o       = ack;
  assign bus.busy_o      = busy;
  assign bus.res_o       = res;
  assign bus.res_valid_o = res_valid;
  assign bus.res_id_o    = res_id;

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler that shares one unsigned W-bit shift-add multiplier among N requesters (DDS channel amplitude/phase scaling). It captures a requester's operands, sequences the multiplier for W cycles, then returns the 2W-bit product tagged with the requester ID. One multiplication is in flight at a time; fairness is strict round-robin.

## Interface
- `W`, 12, operand width (unsigned); must be ≥ 2
- `N`, 4, number of requesters; must be ≥ 2
- `IDW`, $clog2(N), requester ID width (derived, not overridden)
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_i`  in  N  per-requester request; held until that requester's ack
- `a_i`  in  N*W  packed operand A; requester k at [k*W +: W]
- `b_i`  in  N*W  packed operand B; same packing
- `ack_o`  out  N  one-hot, one-cycle pulse: operands of that requester captured
- `busy_o`  out  1  high while state ≠ IDLE
- `res_o`  out  2W  product of last completed operation
- `res_valid_o`  out  1  one-cycle pulse: `res_o`/`res_id_o` new
- `res_id_o`  out  IDW  requester ID of `res_o`

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: if `req_i` ≠ 0, select winner = first set bit searching from `ptr+1` upward, mod N. At the edge: latch a/b of winner, `ack_o` ← onehot(winner), `id` ← winner, start core, go RUN. If `req_i` = 0, stay IDLE.
- RUN: core performs one shift-add step per cycle; after exactly W steps go DONE.
- DONE: `res_o` ← product, `res_id_o` ← id, `res_valid_o` = 1, `ptr` ← id, go IDLE.
- `ptr` reset value N-1, so requester 0 wins first after reset.
- Requester contract: operands stable while `req_i[k]` high; drop `req_i[k]` the cycle `ack_o[k]` is seen. A request still high in IDLE after ack is a new request.
- Requests arriving during RUN/DONE are not acked until next IDLE; no request is lost while held.
- Arithmetic: unsigned, exact: res = a*b, 2W bits, no truncation. Partial sum is W+1 bits (carry kept). Max case (2^W−1)^2 exact.
- `res_o`, `res_id_o` hold last value between completions.
- Reset (any cycle, incl. mid-RUN): state IDLE, `ptr` N-1, `ack_o` 0, `busy_o` 0, `res_o` 0, `res_valid_o` 0, `res_id_o` 0; in-flight product discarded, no `res_valid_o` produced for it.

## Timing
- All outputs registered.
- Edge E0 (IDLE, request present) → `ack_o` high and `busy_o` high in cycle after E0, for exactly one cycle (ack).
- RUN occupies W cycles; DONE cycle follows: `res_valid_o` high W+1 cycles after `ack_o` rises.
- IDLE occupies at least one cycle between operations: issue period W+2 cycles under continuous load (14 for W=12).
- `res_valid_o` and the next `ack_o` never coincide.

## Structure
- Package `mult_arb_pkg`: state enum (IDLE/RUN/DONE), default W/N constants, onehot/ID helper function.
- Sub-module `shift_add_core`: inputs `clk`, `rst_n`, `start`, `a`, `b`; outputs `product` (2W), `done`. W-cycle LSB-first shift-add with W+1-bit accumulator and $clog2(W+1)-bit step counter; `start` ignored while running. Arbiter owns FSM, round-robin pointer, and output registers.

## Test plan
- Single: W=12, req_i=4'b0001, a=3, b=5 → ack_o=0001 one cycle; res_valid_o 13 cycles later, res_o=15, res_id_o=0.
- Extremes: a=4095,b=4095 → res_o=16769025; a=0,b=4095 → 0; a=1,b=2048 → 2048.
- Fairness: all four req held (re-raised after ack) → ack order 0,1,2,3,0,…; consecutive acks 14 cycles apart; each res_id matches ack order.
- Pointer: after grant to 2, req_i=4'b0101 → grant 0 next (search from 3 wraps), then 2.
- Late arrival: req_i[1] raised mid-RUN of req 3 → not acked until after res_valid (id 3); then acked; no duplicate ack.
- Reset mid-RUN: rst_n low 1 cycle at RUN step 5 → all outputs 0 next cycle, no res_valid for aborted op; subsequent req 0 (a=7,b=9) → res_o=63, id 0.
